clock_time_ctrl: RTL
====================

Name: clock_time_ctrl

Overview:
Timekeeping controller that sequences the BCD seconds/minutes/hours counter chain of the digital clock.
- Advances time on each 1 Hz tick from the prescaler.
- Provides a button-driven set mode that selects one field and increments it.
- Sits between the prescaler/button inputs and the 7-segment display driver.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages in each button synchronizer (min 2)
BLINK_TICKS, 1, ticks per blink half-period for the selected field (used only with CTC_BLINK_EN)

Ports:
in_clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
tick  input  1  one-cycle pulse, 1 per second, synchronous to in_clk
mode_btn  input  1  raw mode button, asynchronous, active-high
inc_btn  input  1  raw increment button, asynchronous, active-high
sec_u  output  4  seconds units, BCD 0-9
sec_t  output  4  seconds tens, BCD 0-5
min_u  output  4  minutes units, BCD 0-9
min_t  output  4  minutes tens, BCD 0-5
hour_u  output  4  hours units, BCD 0-9 (0-3 when hour_t=2)
hour_t  output  4  hours tens, BCD 0-2
mode  output  2  FSM state: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
day_pulse  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 wrap
blank  output  6  per-digit blank mask {hour_t,hour_u,min_t,min_u,sec_t,sec_u}; present only with CTC_BLINK_EN

Behaviour:
- Reset: async on rst low.
  - All digits 0, mode=RUN, day_pulse=0, blank=0.
  - Synchronizers and edge detectors are cleared.
  - Reset mid-set discards any edit in progress.
- Buttons:
  - Each button passes through SYNC_STAGES flops, then a rising-edge detector, giving a one-cycle pulse (mode_p, inc_p).
  - Latency from raw edge to pulse is SYNC_STAGES+1 cycles.
  - A held button produces exactly one pulse.
- FSM:
  - On mode_p: RUN -> SET_H -> SET_M -> SET_S -> RUN.
  - No other transitions.
- RUN:
  - On tick, time advances by 1 s, visible on outputs the cycle after tick (registered, 1-cycle latency).
  - Carry chain:
    - sec_u 9->0 carries into sec_t.
    - sec_t 5 with sec_u 9 -> 00, carrying into minutes.
    - Minutes follow the same rule, carrying into hours.
    - Hours wrap 23 -> 00; hour_u wraps 9->0 with increment of hour_t when hour_t<2.
  - day_pulse is asserted in the same cycle the outputs become 00:00:00 after a tick.
- SET_H / SET_M / SET_S:
  - tick is ignored; time is frozen.
  - inc_p increments only the selected field modulo its range (hours 0-23, min/sec 0-59).
  - No carry into other fields; day_pulse is never asserted in set states.
  - Entering any set state from RUN changes no digit.
  - On return to RUN, counting resumes from the edited value at the next tick.
- Simultaneous events:
  - mode_p with inc_p: mode_p wins and inc_p is dropped.
  - mode_p with tick in RUN: tick is applied first (time advances), then the state moves to SET_H.
  - inc_p in RUN is ignored.
- Invalid BCD is unreachable. If hours is ever outside 0-23, the next increment forces hours to 00.

Optional Feature:
Macro CTC_BLINK_EN.
- Defined: an internal counter toggles a blink phase every BLINK_TICKS ticks.
  - The counter runs in all states and is cleared by reset.
  - In a set state, the two digits of the selected field have blank=1 during the off phase; all other bits are 0.
  - In RUN, blank=0.
  - An inc_p forces the on phase and restarts the blink counter.
- Undefined: the blank port and the blink counter do not exist; display is never blanked.

Decomposition:
- Package clock_pkg:
  - State encoding constants RUN/SET_H/SET_M/SET_S.
  - Field limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - BCD digit width constant (4).
- Sub-module btn_sync_edge: SYNC_STAGES synchronizer plus rising-edge pulse. Instantiated twice (mode, inc) and shares rst/in_clk.

Test Plan:
- Reset at 12:34:56 mid-SET_M -> all digits 0, mode=0, blank=0 on the cycle rst falls, independent of in_clk.
- Preset 23:59:58 (via set mode), return to RUN, two ticks -> 23:59:59 then 00:00:00, day_pulse=1 for exactly one cycle, aligned with the 00:00:00 outputs.
- From 00:00:00: mode press, then inc pressed 25 times in SET_H -> hours read 01. Minutes and seconds stay 00. Ticks during set cause no change.
- Press mode and inc in the same cycle from RUN -> mode=1 and hours unchanged. Hold inc 100 cycles -> exactly one increment.
- In RUN at 00:00:09, tick in the same cycle as mode_p -> outputs 00:00:10 and mode=1 on the next cycle.
- CTC_BLINK_EN with BLINK_TICKS=1, SET_M:
  - alternate ticks toggle blank between 6'b001100 and 0;
  - an inc press forces blank=0 and restarts the blink counter;
  - in RUN, blank stays 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock timekeeping controller.
// Used by clock_time_ctrl; the optional blink logic there is enabled by CTC_BLINK_EN.
package clock_pkg;

   localparam int BCD_W    = 4;
   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } mode_t;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] units;
   } bcd2_t;

   typedef struct packed {
      logic  wrap;
      bcd2_t val;
   } bcd2_inc_t;

   // Two-digit BCD increment modulo (max_val+1); any out-of-range value collapses to 00 without wrap.
   function automatic bcd2_inc_t bcd2_inc(input bcd2_t v, input int max_val);
      logic [BCD_W-1:0] max_t;
      logic [BCD_W-1:0] max_u;
      bcd2_inc_t        r;
      max_t  = BCD_W'(max_val / 10);
      max_u  = BCD_W'(max_val % 10);
      r.wrap = 1'b0;
      r.val  = v;
      if ((v.tens > max_t) || ((v.tens == max_t) && (v.units > max_u)) || (v.units > BCD_W'(9))) begin
         r.val = '0;
      end else if ((v.tens == max_t) && (v.units == max_u)) begin
         r.val  = '0;
         r.wrap = 1'b1;
      end else if (v.units == BCD_W'(9)) begin
         r.val.units = '0;
         r.val.tens  = v.tens + BCD_W'(1);
      end else begin
         r.val.units = v.units + BCD_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer followed by a registered rising-edge detector.
// Produces a single one-cycle pulse SYNC_STAGES+1 cycles after the raw edge.
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic in_clk,
   input  logic rst,
   input  logic btn_raw,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;
   logic                   prev_d;
   logic                   pulse_q;
   logic                   pulse_d;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
      prev_d  = sync_q[SYNC_STAGES-1];
      pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: BCD hh:mm:ss counter chain with a button-driven set mode.
// Define CTC_BLINK_EN to add the blink counter and the per-digit blank output.
module clock_time_ctrl
   import clock_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int BLINK_TICKS = 1
) (
   input  logic             in_clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             mode_btn,
   input  logic             inc_btn,
   output logic [BCD_W-1:0] sec_u,
   output logic [BCD_W-1:0] sec_t,
   output logic [BCD_W-1:0] min_u,
   output logic [BCD_W-1:0] min_t,
   output logic [BCD_W-1:0] hour_u,
   output logic [BCD_W-1:0] hour_t,
   output logic [1:0]       mode,
   output logic             day_pulse
`ifdef CTC_BLINK_EN
   ,
   output logic [5:0]       blank
`endif
);

   logic      mode_p;
   logic      inc_p;
   logic      inc_take;

   bcd2_t     sec_q, sec_d;
   bcd2_t     min_q, min_d;
   bcd2_t     hour_q, hour_d;
   mode_t     mode_q, mode_d;
   logic      day_pulse_q, day_pulse_d;

   bcd2_inc_t sec_inc;
   bcd2_inc_t min_inc;
   bcd2_inc_t hour_inc;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
      .in_clk  (in_clk),
      .rst     (rst),
      .btn_raw (mode_btn),
      .pulse   (mode_p)
   );

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
      .in_clk  (in_clk),
      .rst     (rst),
      .btn_raw (inc_btn),
      .pulse   (inc_p)
   );

   // A mode press in the same cycle swallows the increment.
   assign inc_take = (mode_q != RUN) && inc_p && !mode_p;

   always_comb begin
      sec_inc     = bcd2_inc(sec_q, SEC_MAX);
      min_inc     = bcd2_inc(min_q, MIN_MAX);
      hour_inc    = bcd2_inc(hour_q, HOUR_MAX);
      sec_d       = sec_q;
      min_d       = min_q;
      hour_d      = hour_q;
      mode_d      = mode_q;
      day_pulse_d = 1'b0;

      if (mode_q == RUN) begin
         if (tick) begin
            sec_d = sec_inc.val;
            if (sec_inc.wrap) begin
               min_d = min_inc.val;
               if (min_inc.wrap) begin
                  hour_d      = hour_inc.val;
                  day_pulse_d = hour_inc.wrap;
               end
            end
         end
      end else if (inc_take) begin
         case (mode_q)
            SET_H:   hour_d = hour_inc.val;
            SET_M:   min_d  = min_inc.val;
            SET_S:   sec_d  = sec_inc.val;
            default: ;
         endcase
      end

      if (mode_p) begin
         case (mode_q)
            RUN:     mode_d = SET_H;
            SET_H:   mode_d = SET_M;
            SET_M:   mode_d = SET_S;
            default: mode_d = RUN;
         endcase
      end
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         sec_q       <= '0;
         min_q       <= '0;
         hour_q      <= '0;
         mode_q      <= RUN;
         day_pulse_q <= 1'b0;
      end else begin
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
         mode_q      <= mode_d;
         day_pulse_q <= day_pulse_d;
      end
   end

   assign sec_u     = sec_q.units;
   assign sec_t     = sec_q.tens;
   assign min_u     = min_q.units;
   assign min_t     = min_q.tens;
   assign hour_u    = hour_q.units;
   assign hour_t    = hour_q.tens;
   assign mode      = mode_q;
   assign day_pulse = day_pulse_q;

`ifdef CTC_BLINK_EN
   localparam int BLINK_CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   logic [BLINK_CW-1:0] blink_cnt_q, blink_cnt_d;
   logic                blink_off_q, blink_off_d;
   logic [5:0]          blank_q, blank_d;

   // Blank is derived from the next mode and phase so it lines up with the mode output.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      if (inc_take) begin
         blink_cnt_d = '0;
         blink_off_d = 1'b0;
      end else if (tick) begin
         if (blink_cnt_q == BLINK_CW'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_CW'(1);
         end
      end

      blank_d = '0;
      if (blink_off_d) begin
         case (mode_d)
            SET_H:   blank_d = 6'b110000;
            SET_M:   blank_d = 6'b001100;
            SET_S:   blank_d = 6'b000011;
            default: blank_d = '0;
         endcase
      end
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
         blank_q     <= '0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
         blank_q     <= blank_d;
      end
   end

   assign blank = blank_q;
`endif

endmodule
